// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    counter_reg;
   logic [XLEN-1:0]     mag_a_reg, mag_b_reg;
   logic                sa_reg, sb_reg, div_reg, zero_reg;
   logic [2*XLEN-1:0]   acc_reg;
   logic [XLEN:0]       rem_reg;
   logic [XLEN-1:0]     quo_reg;
   logic [XLEN-1:0]     hi_reg, lo_reg;
   logic                done_reg;

   logic                is_signed, issue_md, mt_write, last_iter;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_acc_next;
   logic [XLEN+1:0]     div_shift, div_diff;
   logic [2*XLEN-1:0]   prod_final;
   logic [XLEN-1:0]     quo_final, rem_final, a_orig;

   assign is_signed = ~op[0];
   assign issue_md  = (state_reg == IDLE) && start && !flush && !op[2];
   assign mt_write  = (state_reg == IDLE) && start && !flush && (op[2:1] == 2'b10);
   assign last_iter = (counter_reg == CNT_W'(XLEN - 1));

   assign abs_a = (is_signed && a[XLEN-1]) ? -a : a;
   assign abs_b = (is_signed && b[XLEN-1]) ? -b : b;

   // Multiplier sits in the low half of acc_reg and is consumed as the partial product grows.
   assign mul_sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mag_a_reg} : '0);
   assign mul_acc_next = {mul_sum, acc_reg[XLEN-1:1]};

   // The remainder never exceeds the divisor, so the top bit of div_diff is a clean borrow.
   assign div_shift = {rem_reg, quo_reg[XLEN-1]};
   assign div_diff  = div_shift - {2'b00, mag_b_reg};

   assign prod_final = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
   assign quo_final  = (sa_reg ^ sb_reg) ? -quo_reg : quo_reg;
   assign rem_final  = sa_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
   assign a_orig     = sa_reg ? -mag_a_reg : mag_a_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (issue_md) state_next = RUN;
         RUN: begin
            if (flush)          state_next = IDLE;
            else if (last_iter) state_next = FIN;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_reg <= '0;
         mag_a_reg   <= '0;
         mag_b_reg   <= '0;
         sa_reg      <= 1'b0;
         sb_reg      <= 1'b0;
         div_reg     <= 1'b0;
         zero_reg    <= 1'b0;
         acc_reg     <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (issue_md) begin
                  mag_a_reg   <= abs_a;
                  mag_b_reg   <= abs_b;
                  sa_reg      <= is_signed & a[XLEN-1];
                  sb_reg      <= is_signed & b[XLEN-1];
                  div_reg     <= op[1];
                  zero_reg    <= (b == '0);
                  counter_reg <= '0;
                  acc_reg     <= {{XLEN{1'b0}}, abs_b};
                  rem_reg     <= '0;
                  quo_reg     <= abs_a;
               end else if (mt_write) begin
                  if (op[0]) lo_reg <= a;
                  else       hi_reg <= a;
               end
            end
            RUN: begin
               counter_reg <= counter_reg + 1'b1;
               if (div_reg) begin
                  if (!div_diff[XLEN+1]) begin
                     rem_reg <= div_diff[XLEN:0];
                     quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                  end else begin
                     rem_reg <= div_shift[XLEN:0];
                     quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                  end
               end else begin
                  acc_reg <= mul_acc_next;
               end
            end
            FIN: begin
               counter_reg <= '0;
               if (!flush) begin
                  done_reg <= 1'b1;
                  if (!div_reg) begin
                     hi_reg <= prod_final[2*XLEN-1:XLEN];
                     lo_reg <= prod_final[XLEN-1:0];
                  end else if (zero_reg) begin
                     // Divide by zero reports the untouched dividend and an all-ones quotient.
                     hi_reg <= a_orig;
                     lo_reg <= '1;
                  end else begin
                     hi_reg <= rem_final;
                     lo_reg <= quo_final;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, alongside the ALU, taking the same forwarded rs/rt operands. It executes MIPS MULT/MULTU/DIV/DIVU over multiple cycles and holds the results in internal HI/LO registers. It also accepts MTHI/MTLO writes. Its busy output drives the hazard unit, which stalls IF/ID/EX while an operation runs; hi/lo feed the MFHI/MFLO writeback mux.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  issue request; sampled only in IDLE.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP.
a  input  XLEN  rs operand (multiplicand / dividend / MTHI-MTLO data).
b  input  XLEN  rt operand (multiplier / divisor).
flush  input  1  pipeline flush; aborts an in-flight operation.
busy  output  1  high while state is RUN or FIN.
done  output  1  registered one-cycle pulse when HI/LO are written by MULT/DIV.
hi  output  XLEN  HI register.
lo  output  XLEN  LO register.

Behaviour:
- Reset (async): state=IDLE, counter=0, HI=LO=0, busy=0, done=0, all internal operand/accumulator registers=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 with a MULT/DIV op code at edge E0: latch magnitudes of a and b, sign flags (signed ops only), and the op; counter=0; go to RUN.
  - start=1 with op=MTHI/MTLO: write a into HI/LO at that edge; stay IDLE; busy=0; done=0.
  - start=1 with a NOP op code: no effect.
- RUN: one iteration per edge, E1..E32. counter increments each edge; at counter==XLEN-1 go to FIN.
  - Multiply: shift-add into a 2*XLEN-bit accumulator, one multiplier bit per edge, LSB first.
  - Divide: restoring division, one quotient bit per edge, MSB first. Remainder register is XLEN+1 bits.
- FIN (edge E33):
  - Apply sign correction. Product is negated if sa^sb. Quotient is negated if sa^sb; remainder takes the sign of the dividend (sa).
  - MULT/MULTU: HI=product[2*XLEN-1:XLEN], LO=product[XLEN-1:0]. DIV/DIVU: HI=remainder, LO=quotient.
  - done=1 for exactly the cycle after E33; state returns to IDLE.
- Latency: start sampled at E0, results visible on hi/lo and done=1 after E33. busy is 1 from after E0 until after E33, i.e. 33 cycles.
- Issue rules:
  - start while busy is ignored; the hazard unit must hold the instruction.
  - A new start is accepted in the cycle done=1, which is an IDLE cycle.
- hi/lo hold their old values throughout RUN and FIN. They change only at FIN, on an MTHI/MTLO write, or on reset.
- Divide by zero (b==0, signed or unsigned): no trap. HI=a (original, uncorrected), LO=all ones. Same latency and done pulse.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. Same latency.
- flush:
  - flush=1 in RUN or FIN at an edge: state goes to IDLE at that edge, HI/LO unchanged, done stays 0.
  - flush overrides the FIN write on the same edge.
  - flush=1 together with start in IDLE: start is ignored, including MTHI/MTLO.
- reset mid-operation: immediate abort to the reset values; no done pulse.
- Operand inputs a/b are don't-care after E0; the unit uses only its latched copies.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x12345678 b=0 -> HI=0x12345678, LO=0xFFFFFFFF after 33 cycles; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0xDEADBEEF, next cycle MTLO a=0x0000CAFE -> HI/LO updated at each start edge; busy and done stay 0.
- Start MULTU 5*6; assert flush at cycle 10 -> busy=0 next cycle, no done, HI/LO keep previous values. Then start DIVU 100/7 -> LO=14, HI=2.
- Start DIV; assert reset at cycle 20 -> HI=LO=0, busy=0 immediately. start pulsed again while busy -> ignored, single done only.
